// File: rtl/blake2_ctrl_pkg.sv
// Shared types and sizes for the BLAKE2 message controller.
// Holds the FSM state enum and the byte-mask helper used by the packer.
package blake2_ctrl_pkg;

  localparam int BLOCK_W         = 1024;
  localparam int WORDS_PER_BLOCK = 16;
  localparam int LEN_W           = 128;

  typedef enum logic [2:0] {
    IDLE,
    INIT,
    FILL,
    ISSUE,
    WAIT,
    FINAL,
    DONE
  } state_e;

  function automatic logic [63:0] byte_mask(input logic [3:0] nb);
    logic [63:0] m;
    m = '0;
    for (int i = 0; i < 8; i++) begin
      if (4'(i) < nb) m[8*i +: 8] = 8'hff;
    end
    return m;
  endfunction

endpackage

// File: rtl/blake2_blk_packer.sv
// Packs 64-bit message words into the 1024-bit block register.
// A last word is byte-masked and every later word of the block is cleared.
module blake2_blk_packer
  import blake2_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [3:0]         wr_idx,
  input  logic               wr_last,
  input  logic [3:0]         wr_bytes,
  input  logic [63:0]        wr_data,
  output logic [BLOCK_W-1:0] block_o
);

  logic [WORDS_PER_BLOCK-1:0][63:0] blk_q, blk_d;
  logic [63:0] mask;

  always_comb begin
    blk_d = blk_q;
    mask  = wr_last ? byte_mask(wr_bytes) : '1;
    if (wr_en) begin
      for (int j = 0; j < WORDS_PER_BLOCK; j++) begin
        if (4'(j) == wr_idx) begin
          blk_d[j] = wr_data & mask;
        end else if (wr_last && (4'(j) > wr_idx)) begin
          blk_d[j] = '0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) blk_q <= '0;
    else          blk_q <= blk_d;
  end

  assign block_o = blk_q;

endmodule

// File: rtl/blake2_msg_ctrl.sv
// BLAKE2 message controller: packs words into blocks and sequences core commands.
// Optional sticky error output enabled by BLAKE2_MSG_CTRL_ERR_EN.
module blake2_msg_ctrl
  import blake2_ctrl_pkg::*;
#(
  parameter int WORD_W   = 64,
  parameter int DIGEST_W = 88
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [WORD_W-1:0]   in_data,
  input  logic                in_last,
  input  logic [3:0]          in_bytes,
  output logic                core_init,
  output logic                core_next,
  output logic                core_final,
  output logic [BLOCK_W-1:0]  core_block,
  output logic [LEN_W-1:0]    core_length,
  input  logic                core_ready,
  input  logic                core_digest_valid,
  input  logic [DIGEST_W-1:0] core_digest,
  output logic                dgst_valid,
  input  logic                dgst_ready,
  output logic [DIGEST_W-1:0] dgst_data,
`ifdef BLAKE2_MSG_CTRL_ERR_EN
  output logic                err,
`endif
  output logic                busy
);

  state_e              state_q, state_d;
  logic [3:0]          idx_q, idx_d;
  logic [LEN_W-1:0]    len_q, len_d;
  logic                init_q, init_d;
  logic                next_q, next_d;
  logic                fin_q, fin_d;
  logic                sent_q, sent_d;
  logic                dv_q, dv_d;
  logic [DIGEST_W-1:0] dd_q, dd_d;
  logic                acc;
  logic [3:0]          nb;

  assign acc = in_valid && (state_q == FILL);
  assign nb  = (in_bytes > 4'd8) ? 4'd8 : in_bytes;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    init_d  = 1'b0;
    next_d  = 1'b0;
    fin_d   = 1'b0;
    sent_d  = sent_q;
    dv_d    = dv_q;
    dd_d    = dd_q;
    unique case (state_q)
      IDLE: begin
        len_d  = '0;
        idx_d  = '0;
        sent_d = 1'b0;
        if (in_valid) state_d = INIT;
      end
      INIT: begin
        if (core_ready) begin
          init_d  = 1'b1;
          state_d = FILL;
        end
      end
      FILL: begin
        if (acc) begin
          idx_d = idx_q + 4'd1;
          if (in_last) begin
            len_d   = len_q + LEN_W'(nb);
            state_d = FINAL;
          end else begin
            len_d = len_q + LEN_W'(8);
            if (idx_q == 4'(WORDS_PER_BLOCK - 1)) state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        if (core_ready) begin
          next_d  = 1'b1;
          state_d = WAIT;
        end
      end
      // ready is still high while the pulse is visible; skip that cycle
      WAIT: begin
        if (!next_q && core_ready) state_d = FILL;
      end
      FINAL: begin
        if (!sent_q) begin
          if (core_ready) begin
            fin_d  = 1'b1;
            sent_d = 1'b1;
          end
        end else if (core_digest_valid) begin
          dd_d    = core_digest;
          dv_d    = 1'b1;
          state_d = DONE;
        end
      end
      DONE: begin
        if (dv_q && dgst_ready) begin
          dv_d    = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      init_q  <= 1'b0;
      next_q  <= 1'b0;
      fin_q   <= 1'b0;
      sent_q  <= 1'b0;
      dv_q    <= 1'b0;
      dd_q    <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      init_q  <= init_d;
      next_q  <= next_d;
      fin_q   <= fin_d;
      sent_q  <= sent_d;
      dv_q    <= dv_d;
      dd_q    <= dd_d;
    end
  end

  blake2_blk_packer u_packer (
    .clk      (clk),
    .reset_n  (reset_n),
    .wr_en    (acc),
    .wr_idx   (idx_q),
    .wr_last  (in_last),
    .wr_bytes (nb),
    .wr_data  (in_data),
    .block_o  (core_block)
  );

`ifdef BLAKE2_MSG_CTRL_ERR_EN
  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (state_q == INIT) err_d = 1'b0;
    if (acc && in_last && (in_bytes > 4'd8)) err_d = 1'b1;
    if (core_digest_valid && (state_q != FINAL)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) err_q <= 1'b0;
    else          err_q <= err_d;
  end

  assign err = err_q;
`endif

  assign in_ready    = (state_q == FILL);
  assign busy        = (state_q != IDLE);
  assign core_init   = init_q;
  assign core_next   = next_q;
  assign core_final  = fin_q;
  assign core_length = len_q;
  assign dgst_valid  = dv_q;
  assign dgst_data   = dd_q;

endmodule
